// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and constants for the uart_rx control/buffer slice.
package uart_rx_ctrl_pkg;

  // Storage width for prescale inside the config record.
  // Wide enough for any practical PWIDTH; the top truncates on output.
  localparam int CFG_PRESCALE_W = 16;

  // Smallest oversampling ratio the receiver can work with.
  localparam int MIN_PRESCALE = 4;

  // Receiver configuration record: one active copy, one pending copy.
  typedef struct packed {
    logic [CFG_PRESCALE_W-1:0] prescale;
    logic                      parity_en;
    logic                      parity_type;
  } uart_rx_cfg_t;

  // Configuration after reset: 8x oversampling, parity off, even parity.
  localparam uart_rx_cfg_t CFG_RESET_DEFAULT = '{
    prescale:    16'd8,
    parity_en:   1'b0,
    parity_type: 1'b0
  };

  // Bits in one frame: start + data + parity slot + stop.
  function automatic int frame_bits(input int dwidth);
    return dwidth + 3;
  endfunction

  // Reset configuration with a caller-chosen prescale.
  function automatic uart_rx_cfg_t cfg_default(input int prescale);
    uart_rx_cfg_t c;
    c          = CFG_RESET_DEFAULT;
    c.prescale = CFG_PRESCALE_W'(prescale);
    return c;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Valid/ready byte stream carrying received data out of the controller.
interface uart_rx_ctrl_if #(
  parameter int DWIDTH = 8
);

  logic [DWIDTH-1:0] m_data;
  logic              m_valid;
  logic              m_ready;

  // Producer side: the controller presents data and valid.
  modport master (
    output m_data,
    output m_valid,
    input  m_ready
  );

  // Consumer side: accepts the head with ready.
  modport slave (
    input  m_data,
    input  m_valid,
    output m_ready
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO for received bytes. Head is read combinationally.
// A push while full is only taken when a pop happens in the same cycle;
// a pop while empty is ignored.
module uart_rx_fifo #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DWIDTH-1:0]        din,
  input  logic                     pop,
  output logic [DWIDTH-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count_r;
  logic              pop_ok;
  logic              push_ok;

  assign empty   = (count_r == '0);
  assign full    = (count_r == CW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // When full, the slot being written is the one the pop frees this cycle.
  assign push_ok = push & (~full | pop_ok);

  assign dout  = mem[rd_ptr];
  assign count = count_r;

  // Storage write; data is never reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Control and buffering in front of uart_rx: stages configuration writes and
// applies them only between frames, buffers received bytes in a FIFO, and
// counts bytes lost to overrun.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int DWIDTH       = 8,
  parameter int PWIDTH       = 6,
  parameter int DEPTH        = 4,
  parameter int RST_PRESCALE = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  // configuration request
  input  logic                   cfg_wr,
  input  logic [PWIDTH-1:0]      cfg_prescale,
  input  logic                   cfg_parity_en,
  input  logic                   cfg_parity_type,
  output logic                   cfg_pending,
  output logic                   cfg_err,
  // serial line, observed only
  input  logic                   s_data,
  // active configuration towards uart_rx
  output logic [PWIDTH-1:0]      rx_prescale,
  output logic                   rx_parity_en,
  output logic                   rx_parity_type,
  // bytes from uart_rx
  input  logic [DWIDTH-1:0]      rx_p_data,
  input  logic                   rx_data_valid,
  // buffered output stream
  uart_rx_ctrl_if.master         m_if,
  output logic [$clog2(DEPTH):0] fifo_count,
  // status
  output logic                   line_idle,
  output logic                   overrun,
  output logic [7:0]             overrun_cnt
);

  localparam int FRAME_BITS = frame_bits(DWIDTH);
  localparam int IDLE_W     = $clog2(FRAME_BITS * ((1 << PWIDTH) - 1) + 1);
  localparam uart_rx_cfg_t CFG_RST = cfg_default(RST_PRESCALE);

  uart_rx_cfg_t      act_cfg;
  uart_rx_cfg_t      pend_cfg;
  logic              prescale_ok;
  logic              cfg_accept;
  logic              apply;
  logic [IDLE_W-1:0] idle_cnt;
  logic [IDLE_W-1:0] idle_limit;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic              drop;

  // ---------------------------------------------------------------------------
  // Configuration staging
  // ---------------------------------------------------------------------------
  assign prescale_ok = (cfg_prescale >= PWIDTH'(MIN_PRESCALE));
  assign cfg_accept  = cfg_wr & prescale_ok;

  // A frame boundary is either a quiet line or the end-of-frame byte strobe.
  assign apply = cfg_pending & (line_idle | rx_data_valid);

  assign rx_prescale    = act_cfg.prescale[PWIDTH-1:0];
  assign rx_parity_en   = act_cfg.parity_en;
  assign rx_parity_type = act_cfg.parity_type;

  // Pending copy is data only; its validity lives in cfg_pending.
  always_ff @(posedge clk) begin
    if (cfg_accept) begin
      pend_cfg.prescale    <= CFG_PRESCALE_W'(cfg_prescale);
      pend_cfg.parity_en   <= cfg_parity_en;
      pend_cfg.parity_type <= cfg_parity_type;
    end
  end

  // Active config, pending flag and reject pulse. A write landing in the same
  // cycle as an apply becomes the new pending value while the older one goes live.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_cfg     <= CFG_RST;
      cfg_pending <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      cfg_err <= cfg_wr & ~prescale_ok;
      if (apply) begin
        act_cfg <= pend_cfg;
      end
      if (cfg_accept) begin
        cfg_pending <= 1'b1;
      end else if (apply) begin
        cfg_pending <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Idle-line detection: one full frame time of continuous high line
  // ---------------------------------------------------------------------------
  // The line is used as-is; the receiver sees the same unsynchronised level.
  assign idle_limit = IDLE_W'(FRAME_BITS * int'(act_cfg.prescale));
  assign line_idle  = (idle_cnt == idle_limit);

  // Count consecutive high cycles; restart on a low bit or a config switch
  // so the frame time is always measured at the current baud.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (apply || !s_data) begin
      idle_cnt <= '0;
    end else if (idle_cnt < idle_limit) begin
      idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Receive buffer
  // ---------------------------------------------------------------------------
  assign fifo_pop = m_if.m_valid & m_if.m_ready;

  uart_rx_fifo #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_data_valid),
    .din   (rx_p_data),
    .pop   (fifo_pop),
    .dout  (m_if.m_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign m_if.m_valid = ~fifo_empty;

  // ---------------------------------------------------------------------------
  // Overrun accounting
  // ---------------------------------------------------------------------------
  // A byte is lost only when the buffer is full and nothing leaves this cycle.
  assign drop = rx_data_valid & fifo_full & ~fifo_pop;

  // Registered drop pulse and saturating loss counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun     <= 1'b0;
      overrun_cnt <= 8'd0;
    end else begin
      overrun <= drop;
      if (drop && overrun_cnt != 8'hFF) begin
        overrun_cnt <= overrun_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed scenarios plus randomized traffic, checked
// against a behavioural model (byte queue, pending/active config, high-run length).
module tb_uart_rx_ctrl;

  localparam int DW    = 8;
  localparam int PW    = 6;
  localparam int DEPTH = 4;
  localparam int FRAME = DW + 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_wr = 1'b0;
  logic [PW-1:0] cfg_prescale = '0;
  logic          cfg_parity_en = 1'b0;
  logic          cfg_parity_type = 1'b0;
  logic          cfg_pending;
  logic          cfg_err;
  logic          s_data = 1'b1;
  logic [PW-1:0] rx_prescale;
  logic          rx_parity_en;
  logic          rx_parity_type;
  logic [DW-1:0] rx_p_data = '0;
  logic          rx_data_valid = 1'b0;
  logic          m_ready = 1'b0;
  logic [2:0]    fifo_count;
  logic          line_idle;
  logic          overrun;
  logic [7:0]    overrun_cnt;

  uart_rx_ctrl_if #(.DWIDTH(DW)) m_if ();
  assign m_if.m_ready = m_ready;

  uart_rx_ctrl #(
    .DWIDTH(DW), .PWIDTH(PW), .DEPTH(DEPTH), .RST_PRESCALE(8)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_wr(cfg_wr), .cfg_prescale(cfg_prescale),
    .cfg_parity_en(cfg_parity_en), .cfg_parity_type(cfg_parity_type),
    .cfg_pending(cfg_pending), .cfg_err(cfg_err),
    .s_data(s_data),
    .rx_prescale(rx_prescale), .rx_parity_en(rx_parity_en), .rx_parity_type(rx_parity_type),
    .rx_p_data(rx_p_data), .rx_data_valid(rx_data_valid),
    .m_if(m_if),
    .fifo_count(fifo_count), .line_idle(line_idle),
    .overrun(overrun), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  int  mcnt = 0;
  int  m_ovf_cnt = 0;
  bit  m_ovf = 0;
  bit  m_err = 0;
  bit  pend_f = 0;
  int  pend_ps = 0;
  bit  pend_pe = 0, pend_pt = 0;
  int  act_ps = 8;
  bit  act_pe = 0, act_pt = 0;
  int  run = 0;
  logic [DW-1:0] mon_exp;

  task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, a, a, e, e, $time);
    else n_pass++;
  endtask

  // Scoreboard monitor: compares every accepted head against the model queue.
  always @(negedge clk) begin
    if (!rst && m_if.m_valid === 1'b1 && m_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL pop_unexpected: got 0x%0h expected no data at %0t", m_if.m_data, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("pop_data", m_if.m_data, mon_exp);
      end
      got_q.push_back(m_if.m_data);
    end
  end

  // One clock: model advances on the edge, outputs checked 1 time unit later.
  task automatic tick();
    bit pop, accepted, idle_now, apply;
    @(posedge clk);
    if (rst) begin
      mcnt = 0; exp_q.delete(); m_ovf = 0; m_ovf_cnt = 0; m_err = 0;
      pend_f = 0; act_ps = 8; act_pe = 0; act_pt = 0; run = 0;
    end else begin
      pop      = m_ready && (mcnt > 0);
      m_ovf    = rx_data_valid && (mcnt == DEPTH) && !pop;
      accepted = rx_data_valid && !m_ovf;
      if (m_ovf && m_ovf_cnt < 255) m_ovf_cnt++;
      if (accepted) exp_q.push_back(rx_p_data);
      mcnt = mcnt + int'(accepted) - int'(pop);
      idle_now = (run >= FRAME * act_ps);
      apply    = pend_f && (idle_now || rx_data_valid);
      m_err    = cfg_wr && (cfg_prescale < 4);
      if (apply) begin
        act_ps = pend_ps; act_pe = pend_pe; act_pt = pend_pt;
      end
      if (cfg_wr && cfg_prescale >= 4) begin
        pend_ps = int'(cfg_prescale); pend_pe = cfg_parity_en; pend_pt = cfg_parity_type;
        pend_f = 1;
      end else if (apply) begin
        pend_f = 0;
      end
      if (apply || !s_data) run = 0;
      else run++;
    end
    #1;
    check("m_valid", m_if.m_valid, mcnt > 0);
    check("fifo_count", fifo_count, mcnt);
    check("overrun", overrun, m_ovf);
    check("overrun_cnt", overrun_cnt, m_ovf_cnt);
    check("cfg_err", cfg_err, m_err);
    check("cfg_pending", cfg_pending, pend_f);
    check("rx_prescale", rx_prescale, act_ps);
    check("rx_parity_en", rx_parity_en, act_pe);
    check("rx_parity_type", rx_parity_type, act_pt);
    check("line_idle", line_idle, run >= FRAME * act_ps);
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_data_valid = 1'b1; rx_p_data = b;
    tick();
    rx_data_valid = 1'b0;
  endtask

  initial begin
    int rdy_pct;
    int run_left;
    rdy_pct = 50;
    run_left = 0;

    // reset, then a quiet line for one frame time at the default prescale
    rst = 1'b1; s_data = 1'b1;
    tick();
    check("rst_m_valid", m_if.m_valid, 0);
    check("rst_prescale", rx_prescale, 8);
    rst = 1'b0;
    repeat (87) tick();
    check("idle_87", line_idle, 0);
    tick();
    check("idle_88", line_idle, 1);
    check("def_parity_en", rx_parity_en, 0);

    // config write on an idle line applies two cycles later
    cfg_wr = 1'b1; cfg_prescale = 6'd16; cfg_parity_en = 1'b1; cfg_parity_type = 1'b1;
    tick();
    cfg_wr = 1'b0;
    check("wr_pending", cfg_pending, 1);
    tick();
    check("applied_ps", rx_prescale, 16);
    check("applied_pt", rx_parity_type, 1);
    check("idle_dropped", line_idle, 0);
    repeat (175) tick();
    check("idle_175", line_idle, 0);
    tick();
    check("idle_176", line_idle, 1);

    // mid-frame write waits for the byte strobe
    s_data = 1'b0;
    repeat (5) tick();
    cfg_wr = 1'b1; cfg_prescale = 6'd16; cfg_parity_en = 1'b0; cfg_parity_type = 1'b0;
    tick();
    cfg_wr = 1'b0;
    repeat (3) tick();
    check("midframe_hold", rx_parity_en, 1);
    push_byte(8'h3C);
    check("strobe_apply_pe", rx_parity_en, 0);
    check("strobe_apply_pend", cfg_pending, 0);
    m_ready = 1'b1;
    repeat (2) tick();
    m_ready = 1'b0;
    s_data = 1'b1;

    // undersized prescale is rejected
    cfg_wr = 1'b1; cfg_prescale = 6'd2;
    tick();
    cfg_wr = 1'b0;
    check("reject_err", cfg_err, 1);
    check("reject_pend", cfg_pending, 0);
    check("reject_ps", rx_prescale, 16);
    tick();
    check("reject_err_clr", cfg_err, 0);

    // overrun with a stalled consumer
    for (int i = 0; i < 5; i++) push_byte(8'hA1 + 8'(i));
    check("ovr_count", fifo_count, 4);
    check("ovr_pulse", overrun, 1);
    check("ovr_cnt", overrun_cnt, 1);
    tick();
    check("ovr_pulse_end", overrun, 0);
    got_q.delete();
    m_ready = 1'b1;
    repeat (5) tick();
    check("drain_n", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) check("drain_order", got_q[i], 8'hA1 + 8'(i));

    // full buffer, push during pop
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_byte(8'h11 + 8'(i));
    m_ready = 1'b1;
    push_byte(8'h5C);
    check("fullpop_ovr", overrun, 0);
    check("fullpop_count", fifo_count, 4);
    got_q.delete();
    repeat (4) tick();
    check("fullpop_n", got_q.size(), 4);
    if (got_q.size() == 4) check("fullpop_last", got_q[3], 8'h5C);

    // reset mid-stream flushes the buffer
    m_ready = 1'b0;
    push_byte(8'h77);
    push_byte(8'h78);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_flush_valid", m_if.m_valid, 0);
    check("rst_flush_count", fifo_count, 0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (c % 50 == 0) rdy_pct = $urandom_range(0, 100);
      if (run_left == 0) begin
        s_data   = ~s_data;
        run_left = s_data ? $urandom_range(1, 300) : $urandom_range(1, 40);
      end
      run_left--;
      m_ready         = ($urandom_range(0, 99) < rdy_pct);
      rx_data_valid   = ($urandom_range(0, 99) < 15);
      rx_p_data       = 8'($urandom);
      cfg_wr          = ($urandom_range(0, 99) < 3);
      cfg_prescale    = 6'($urandom_range(0, 20));
      cfg_parity_en   = 1'($urandom);
      cfg_parity_type = 1'($urandom);
      rst             = ($urandom_range(0, 999) < 2);
      tick();
    end

    // final drain
    rst = 1'b0; cfg_wr = 1'b0; rx_data_valid = 1'b0; m_ready = 1'b1;
    repeat (10) tick();
    check("final_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Control and buffering block placed in front of `uart_rx`. It owns the receiver's configuration (prescale, parity enable, parity type) and changes it only at frame boundaries, never mid-frame. It captures every received byte into a small FIFO exposed as a valid/ready stream. It also counts bytes lost to overrun.

## Interface
- `DWIDTH`, 8, data bits per frame
- `PWIDTH`, 6, prescale field width
- `DEPTH`, 4, receive FIFO entries (power of two, ≥2)
- `RST_PRESCALE`, 8, prescale driven after reset
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `cfg_wr`  in  1  one-cycle request to load new configuration
- `cfg_prescale`  in  PWIDTH  requested oversampling ratio
- `cfg_parity_en`  in  1  requested parity enable
- `cfg_parity_type`  in  1  requested parity type: 0 even, 1 odd
- `cfg_pending`  out  1  a written configuration is waiting to be applied
- `cfg_err`  out  1  one-cycle pulse: `cfg_wr` rejected
- `s_data`  in  1  serial line, monitored only (also wired to `uart_rx`)
- `rx_prescale`  out  PWIDTH  active prescale to `uart_rx`
- `rx_parity_en`  out  1  active parity enable to `uart_rx`
- `rx_parity_type`  out  1  active parity type to `uart_rx`
- `rx_p_data`  in  DWIDTH  byte from `uart_rx`
- `rx_data_valid`  in  1  one-cycle strobe from `uart_rx`
- `m_data`  out  DWIDTH  FIFO head
- `m_valid`  out  1  FIFO not empty
- `m_ready`  in  1  consumer accepts head
- `fifo_count`  out  $clog2(DEPTH)+1  occupancy
- `line_idle`  out  1  line high for one full frame time
- `overrun`  out  1  one-cycle pulse: byte dropped
- `overrun_cnt`  out  8  dropped-byte count, saturates at 255

## Operation
- Reset values:
  - `rx_prescale`=RST_PRESCALE, `rx_parity_en`=0, `rx_parity_type`=0.
  - `cfg_pending`=0, `cfg_err`=0, `m_valid`=0, `fifo_count`=0.
  - `line_idle`=0, `overrun`=0, `overrun_cnt`=0. `m_data` is don't-care.
- Config write:
  - `cfg_wr` with `cfg_prescale` < 4 is ignored and pulses `cfg_err`.
  - Otherwise the values are captured into pending registers, overwriting any older pending value, and `cfg_pending`=1.
- Apply condition: `cfg_pending` and (`line_idle` or `rx_data_valid`).
  - On apply, the pending values are copied to `rx_*` and `cfg_pending` clears.
- Idle counter:
  - Increments each cycle `s_data`=1 and clears on `s_data`=0.
  - Saturates at FRAME_BITS×`rx_prescale`, where FRAME_BITS = DWIDTH+3.
  - `line_idle` = counter at saturation.
  - Counter clears whenever the active config changes.
  - Width is $clog2(FRAME_BITS×(2^PWIDTH−1)+1).
- FIFO behaviour:
  - Push on `rx_data_valid`. Pop when `m_valid`&`m_ready`.
  - Push while full with no pop: byte is dropped, `overrun` pulses, `overrun_cnt` increments (saturating).
  - Push while full with a simultaneous pop: push is accepted, count unchanged.
  - Push and pop while count 1: the new byte becomes head.
  - Pointers wrap modulo DEPTH.
- Reset mid-operation: FIFO flushed, pending config discarded, active config returns to defaults.

## Timing
- `cfg_wr` at cycle N:
  - `cfg_pending`=1 (or `cfg_err`=1) at N+1.
  - If the line is already idle, `rx_*` update at N+2 and `cfg_pending`=0 at N+2.
- `cfg_wr` in the same cycle as an apply: the older pending value is applied at N+1, and the new value stays pending.
- `rx_data_valid` at N: `m_valid`/`m_data`/`fifo_count` reflect the byte at N+1. Any pending config is applied at N+1.
- `m_data` is combinational from the head entry. It is stable while `m_valid`&!`m_ready`.
- `overrun` is registered and asserts at N+1 of the dropped push.

## Structure
- Package `uart_rx_ctrl_pkg`:
  - `uart_rx_cfg_t` struct {prescale, parity_en, parity_type}.
  - FRAME_BITS function of DWIDTH.
  - MIN_PRESCALE = 4.
  - Reset-default constant.
- Sub-module `uart_rx_fifo` (DWIDTH, DEPTH): push/pop/full/empty/count. The controller holds the config staging, idle counter and overrun logic.

## Test plan
- Reset, then hold `s_data`=1 for 88 cycles → `line_idle`=1 at cycle 88, `rx_prescale`=8, `rx_parity_en`=0.
- Idle line, `cfg_wr` {16,1,1} → `cfg_pending` at N+1; `rx_prescale`=16, `rx_parity_en`=1, `rx_parity_type`=1 at N+2; `line_idle` drops, then re-asserts after 176 high cycles.
- Mid-frame (`s_data`=0 at cycle 5), `cfg_wr` {16,0,0} → `rx_*` unchanged until the `rx_data_valid` strobe, updated the next cycle.
- `cfg_wr` with prescale=2 → `cfg_err` pulse, `cfg_pending`=0, config unchanged.
- With `m_ready`=0, push 5 bytes 0xA1..0xA5 at DEPTH=4 → `fifo_count`=4, one `overrun` pulse, `overrun_cnt`=1. Then pull with `m_ready`=1 → 0xA1,0xA2,0xA3,0xA4 in order.
- Full FIFO, push 0x5C while popping → no overrun, `fifo_count` stays 4, 0x5C is read last. Assert `rst` mid-stream → `m_valid`=0 and `fifo_count`=0 next cycle.
